// File: rtl/input_debouncer_if.sv
// Board-side bundle for the two-channel input debouncer: raw switch levels in,
// debounced levels and one-cycle change pulses out.
`timescale 1ns/1ps

interface input_debouncer_if;
    logic rawInput1;
    logic rawInput2;
    logic input1;
    logic input2;
    logic changed1;
    logic changed2;

    // Board / stimulus side: drives raw levels, consumes the clean outputs.
    modport master (
        output rawInput1,
        output rawInput2,
        input  input1,
        input  input2,
        input  changed1,
        input  changed2
    );

    // Debouncer side: consumes raw levels, produces the clean outputs.
    modport slave (
        input  rawInput1,
        input  rawInput2,
        output input1,
        output input2,
        output changed1,
        output changed2
    );
endinterface

// File: rtl/input_debouncer.sv
// Two independent input conditioners. Each channel has a two-flop synchronizer
// followed by a STABLE/PENDING filter. The filter only lets the output follow
// the synchronized level after it has differed from the output for StableCount
// consecutive cycles, and it emits a one-cycle pulse on every accepted toggle.
`timescale 1ns/1ps

module input_debouncer #(
    parameter int StableCount  = 4,
    parameter int CounterWidth = 16
) (
    input logic               clock,
    input logic               reset,
    input_debouncer_if.slave  bus
);

    // Terminal count: at this value, a PENDING channel that still disagrees
    // with its output commits the toggle on the next edge.
    localparam logic [CounterWidth-1:0] LastCount = CounterWidth'(StableCount - 1);
    localparam logic [CounterWidth-1:0] ZeroCount = '0;
    localparam logic [CounterWidth-1:0] OneCount  = CounterWidth'(1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_e;

    logic [1:0] rawVec;
    logic [1:0] levelVec;
    logic [1:0] pulseVec;

    assign rawVec = {bus.rawInput2, bus.rawInput1};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic                    sync1_q;
        logic                    sync2_q;
        state_e                  state_q;
        state_e                  state_d;
        logic [CounterWidth-1:0] count_q;
        logic [CounterWidth-1:0] count_d;
        logic                    level_q;
        logic                    level_d;
        logic                    changed_q;
        logic                    changed_d;

        // Two-flop synchronizer; any metastability is confined to sync1_q.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= rawVec[ch];
                sync2_q <= sync1_q;
            end
        end

        // Filter state, stability counter, clean level and change pulse.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q   <= STABLE;
                count_q   <= ZeroCount;
                level_q   <= 1'b0;
                changed_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                count_q   <= count_d;
                level_q   <= level_d;
                changed_q <= changed_d;
            end
        end

        // Next-state logic: a disagreement must persist unbroken for
        // StableCount cycles; any return to the current level restarts from zero.
        always_comb begin
            state_d   = state_q;
            count_d   = count_q;
            level_d   = level_q;
            changed_d = 1'b0;
            case (state_q)
                STABLE: begin
                    if (sync2_q != level_q) begin
                        state_d = PENDING;
                        count_d = OneCount;
                    end else begin
                        count_d = ZeroCount;
                    end
                end
                PENDING: begin
                    if (sync2_q == level_q) begin
                        state_d = STABLE;
                        count_d = ZeroCount;
                    end else if (count_q == LastCount) begin
                        state_d   = STABLE;
                        count_d   = ZeroCount;
                        level_d   = ~level_q;
                        changed_d = 1'b1;
                    end else begin
                        count_d = count_q + OneCount;
                    end
                end
                default: begin
                    state_d = STABLE;
                    count_d = ZeroCount;
                end
            endcase
        end

        assign levelVec[ch] = level_q;
        assign pulseVec[ch] = changed_q;
    end

    assign bus.input1   = levelVec[0];
    assign bus.input2   = levelVec[1];
    assign bus.changed1 = pulseVec[0];
    assign bus.changed2 = pulseVec[1];

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (StableCount = 4). Expected output
// vectors {input1, input2, changed1, changed2} are queued per clock edge as the
// stimulus is driven and are compared one cycle slot at a time after each edge.
`timescale 1ns/1ps

module tb_input_debouncer;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] val;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   e;
    int   tmp;
    exp_t sb[$];

    input_debouncer_if bus ();

    input_debouncer #(
        .StableCount  (4),
        .CounterWidth (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare the live outputs against one expected vector.
    task automatic checkOutput(input string tag, input logic [3:0] expected);
        logic [3:0] observed;
        observed = {bus.input1, bus.input2, bus.changed1, bus.changed2};
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Drive both raw levels at a falling edge; edgeIdx is the rising edge that
    // first samples them into sync1.
    task automatic applyStimulus(input logic r1, input logic r2, output int edgeIdx);
        @(negedge clock);
        bus.rawInput1 = r1;
        bus.rawInput2 = r2;
        edgeIdx = cyc + 1;
    endtask

    // Queue the same expected vector for every edge in [fromCyc, toCyc].
    task automatic expectSpan(input int fromCyc, input int toCyc, input string tag,
                              input logic [3:0] val);
        exp_t item;
        for (int c = fromCyc; c <= toCyc; c++) begin
            item.cyc = c;
            item.tag = tag;
            item.val = val;
            sb.push_back(item);
        end
    endtask

    // Standard single-channel-1 rise from rest, E = first sampling edge.
    task automatic expectRise1(input int edgeIdx, input string tag);
        expectSpan(edgeIdx,     edgeIdx + 4, {tag, "_wait"}, 4'b0000);
        expectSpan(edgeIdx + 5, edgeIdx + 5, {tag, "_rise"}, 4'b1010);
        expectSpan(edgeIdx + 6, edgeIdx + 8, {tag, "_hold"}, 4'b1000);
    endtask

    // Wait (bounded) until every queued expectation has been compared.
    task automatic waitDrain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clock);
            guard++;
        end
        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("[TB] FAIL %s_drain: pending=%0d expected=0", tag, sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard consumer: after each rising edge, compare all entries due now.
    initial begin
        exp_t item;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                item = sb.pop_front();
                checkOutput($sformatf("%s@%0d", item.tag, item.cyc), item.val);
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.rawInput1 = 1'b0;
        bus.rawInput2 = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_hold", 4'b0000);

        // Release reset, then raise channel 1 and hold it.
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, e);
        expectRise1(e, "rst_rel");
        waitDrain("rst_rel");

        // Asynchronous reset mid-cycle while rawInput1 stays high.
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("rst_async", 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        e = cyc + 1;
        expectRise1(e, "rst_exit");
        waitDrain("rst_exit");

        // Clean press on channel 2, held 20 cycles, then released.
        applyStimulus(1'b1, 1'b1, e);
        expectSpan(e,     e + 4,  "press2_wait", 4'b1000);
        expectSpan(e + 5, e + 5,  "press2_rise", 4'b1101);
        expectSpan(e + 6, e + 19, "press2_hold", 4'b1100);
        waitDrain("press2");
        applyStimulus(1'b1, 1'b0, e);
        expectSpan(e,     e + 4, "rel2_wait", 4'b1100);
        expectSpan(e + 5, e + 5, "rel2_fall", 4'b1001);
        expectSpan(e + 6, e + 8, "rel2_hold", 4'b1000);
        waitDrain("rel2");

        // Bring channel 1 back low before the bounce sequence.
        applyStimulus(1'b0, 1'b0, e);
        expectSpan(e,     e + 4, "rel1_wait", 4'b1000);
        expectSpan(e + 5, e + 5, "rel1_fall", 4'b0010);
        expectSpan(e + 6, e + 8, "rel1_hold", 4'b0000);
        waitDrain("rel1");

        // Bounce 1,1,0,0,1,1,0,0 then hold 1; final stable sample at e+8.
        applyStimulus(1'b1, 1'b0, e);
        expectSpan(e,      e + 12, "bounce_wait", 4'b0000);
        expectSpan(e + 13, e + 13, "bounce_rise", 4'b1010);
        expectSpan(e + 14, e + 16, "bounce_hold", 4'b1000);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            bus.rawInput1 = ((k / 2) % 2 == 0);
        end
        waitDrain("bounce");

        // Return channel 1 low ahead of the glitch test.
        applyStimulus(1'b0, 1'b0, e);
        expectSpan(e,     e + 4, "rel1b_wait", 4'b1000);
        expectSpan(e + 5, e + 5, "rel1b_fall", 4'b0010);
        expectSpan(e + 6, e + 8, "rel1b_hold", 4'b0000);
        waitDrain("rel1b");

        // Three-cycle glitch: must be rejected entirely.
        applyStimulus(1'b1, 1'b0, e);
        expectSpan(e, e + 10, "glitch3", 4'b0000);
        repeat (2) @(negedge clock);
        applyStimulus(1'b0, 1'b0, tmp);
        waitDrain("glitch3");

        // Exactly four-cycle pulse: accepted, and falls again after the
        // minimum toggle spacing, with full latency proving the counter restarted.
        applyStimulus(1'b1, 1'b0, e);
        expectSpan(e,      e + 4,  "pulse4_wait",  4'b0000);
        expectSpan(e + 5,  e + 5,  "pulse4_rise",  4'b1010);
        expectSpan(e + 6,  e + 8,  "pulse4_high",  4'b1000);
        expectSpan(e + 9,  e + 9,  "pulse4_fall",  4'b0010);
        expectSpan(e + 10, e + 12, "pulse4_low",   4'b0000);
        repeat (3) @(negedge clock);
        applyStimulus(1'b0, 1'b0, tmp);
        waitDrain("pulse4");

        // Simultaneous rise and fall on both channels.
        applyStimulus(1'b1, 1'b1, e);
        expectSpan(e,     e + 4, "both_up_wait", 4'b0000);
        expectSpan(e + 5, e + 5, "both_up_edge", 4'b1111);
        expectSpan(e + 6, e + 8, "both_up_hold", 4'b1100);
        waitDrain("both_up");
        applyStimulus(1'b0, 1'b0, e);
        expectSpan(e,     e + 4, "both_dn_wait", 4'b1100);
        expectSpan(e + 5, e + 5, "both_dn_edge", 4'b0011);
        expectSpan(e + 6, e + 8, "both_dn_hold", 4'b0000);
        waitDrain("both_dn");

        // Reset while channel 1 is PENDING; full latency required afterwards.
        applyStimulus(1'b1, 1'b0, e);
        expectSpan(e, e + 2, "pend_pre", 4'b0000);
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("rst_pend_async", 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        e = cyc + 1;
        expectRise1(e, "rst_pend_exit");
        waitDrain("rst_pend_exit");

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Two-channel input conditioner that sits directly upstream of the lab gate blocks. It takes raw switch/button levels from the board, synchronizes each to the system clock, and filters bounce. It then drives clean levels onto the gate inputs, plus a one-cycle change pulse per channel for the board-level LED/counter logic. Both channels are identical and fully independent.

## Interface
Parameters:
- StableCount, default 4: consecutive synchronized cycles a new level must persist before the output follows it; legal range 2..65535.
- CounterWidth, default 16: width of each channel's stability counter; must satisfy 2^CounterWidth > StableCount.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- rawInput1  input  1  unsynchronized switch level, channel 1.
- rawInput2  input  1  unsynchronized switch level, channel 2.
- input1  output  1  debounced level, channel 1 (feeds gate input1).
- input2  output  1  debounced level, channel 2 (feeds gate input2).
- changed1  output  1  one-cycle pulse when input1 toggles.
- changed2  output  1  one-cycle pulse when input2 toggles.

## Operation
- Per channel: two-flop synchronizer sync1 -> sync2 (both reset to 0), then a 2-state FSM with a counter.
- The FSM compares sync2 with the registered output level (input1/input2).
- STABLE (reset state, counter = 0):
  - sync2 == out: stay; counter stays 0.
  - sync2 != out: go to PENDING; counter <= 1.
- PENDING:
  - sync2 == out: abort; return to STABLE, counter <= 0, out unchanged, no pulse.
  - sync2 != out and counter == StableCount-1: out <= ~out; changed <= 1 for one cycle; counter <= 0; go to STABLE.
  - sync2 != out otherwise: counter <= counter+1.
- When StableCount == 2, the PENDING step at counter 1 toggles on the very next edge.
- The counter never exceeds StableCount-1, so there is no wrap-around; arithmetic is unsigned, CounterWidth bits.
- changed is registered, high exactly one cycle per toggle, and never asserted in consecutive cycles. The minimum spacing between toggles is StableCount cycles.
- Channels share no state. Simultaneous transitions on both raw inputs produce independent, simultaneous results.
- Reset (async, any time, including mid-PENDING):
  - sync1, sync2, input1, input2, changed1, changed2 all go to 0 immediately.
  - Counters go to 0 and FSMs go to STABLE.
  - No pulse is generated on reset entry or exit.

## Timing
- Reset values: input1 = input2 = 0, changed1 = changed2 = 0.
- Latency: raw level first sampled into sync1 at edge E and held steady gives:
  - out changes at edge E+StableCount+1.
  - changed is high in the cycle following that edge.
  - Default StableCount = 4: out updates at E+5.
- Glitch rejection: any raw pulse whose synchronized version lasts fewer than StableCount cycles leaves out and changed untouched.
- A reversal that returns to the current out level during PENDING restarts filtering from zero. There is no partial credit.
- Raw inputs need no setup relation to clock; metastability is confined to sync1.

## Test plan
- Reset: assert reset mid-cycle with rawInput1 = 1 held -> input1/changed1 = 0 immediately. Deassert, raw sampled at edge E -> input1 = 1 at E+5, changed1 pulses exactly one cycle.
- Clean press: rawInput2 0->1 held 20 cycles -> input2 rises at E+5, changed2 high one cycle; rawInput2 1->0 -> input2 falls 5 edges later, one more pulse.
- Bounce: rawInput1 toggles 1,0,1,0 every 2 cycles then holds 1 -> no change during bounce; input1 = 1 exactly 5 edges after the final stable sample; single changed1 pulse.
- Glitch: rawInput1 = 1 for 3 cycles only (StableCount = 4) -> input1 stays 0, changed1 never asserts, FSM back in STABLE with counter 0.
- Simultaneous: both raw inputs 0->1 on the same edge -> input1, input2, changed1, changed2 all switch on the same edge.
- Reset mid-PENDING: raw 0->1, assert reset after 2 edges -> counter/out cleared. After release with raw still 1, full 5-edge latency is required again.
